// File: rtl/encoder_pkg.sv
// Shared types and helpers for the hex-display value controller.
package encoder_pkg;
  localparam int unsigned VALUE_W = 24;

  typedef enum logic [1:0] {IDLE, COUNT, FIRED} enc_state_t;

  typedef struct packed {
    logic valid;
    logic up;
  } req_t;

  // Result bit VALUE_W is the carry (add) or borrow (subtract).
  function automatic logic [VALUE_W:0] step_value(input logic [VALUE_W-1:0] v,
                                                  input logic [VALUE_W-1:0] step,
                                                  input logic up);
    return up ? ({1'b0, v} + {1'b0, step}) : ({1'b0, v} - {1'b0, step});
  endfunction
endpackage

// File: rtl/encoder_value_ctrl_if.sv
// Encoder/clear inputs and value/update outputs of the value controller.
interface encoder_value_ctrl_if;
  import encoder_pkg::*;

  logic               tick;
  logic [1:0]         enc_a;
  logic [1:0]         enc_b;
  logic               clr_sw;
  logic [VALUE_W-1:0] value;
  logic               upd;
  logic               wrap;

  modport master (output tick, enc_a, enc_b, clr_sw, input value, upd, wrap);
  modport slave  (input tick, enc_a, enc_b, clr_sw, output value, upd, wrap);
endinterface

// File: rtl/enc_debounce.sv
// One input channel: 2-flop synchronizers, tick-driven debounce FSM, one request per activation.
module enc_debounce
  import encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter logic        ACTIVE_LVL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic a_async,
  input  logic b_async,
  output req_t req
);
  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]    a_sync, b_sync;
  enc_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          a_on;

  assign a_on = (a_sync[1] == ACTIVE_LVL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sync <= {2{~ACTIVE_LVL}};
      b_sync <= '0;
      state  <= IDLE;
      cnt    <= '0;
    end else begin
      a_sync <= {a_sync[0], a_async};
      b_sync <= {b_sync[0], b_async};
      state  <= state_n;
      cnt    <= cnt_n;
    end
  end

  // The tick that brings the counter to DEBOUNCE_TICKS fires; B is sampled on that tick.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req     = '0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (a_on) begin
            cnt_n   = CW'(1);
            state_n = COUNT;
          end
        end
        COUNT: begin
          if (a_on) cnt_n = cnt + CW'(1);
          else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        FIRED: begin
          if (!a_on) begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      endcase
      if (state != FIRED && a_on && cnt_n == CW'(DEBOUNCE_TICKS)) begin
        req.valid = 1'b1;
        req.up    = b_sync[1];
        state_n   = FIRED;
      end
    end
  end
endmodule

// File: rtl/encoder_value_ctrl.sv
// Debounces two encoders and a clear switch, arbitrates requests into the 24-bit display value.
module encoder_value_ctrl
  import encoder_pkg::*;
#(
  parameter int unsigned        DEBOUNCE_TICKS = 10,
  parameter logic [VALUE_W-1:0] STEP0          = 24'h000001,
  parameter logic [VALUE_W-1:0] STEP1          = 24'h000100
) (
  input  logic clk,
  input  logic rst_n,
  encoder_value_ctrl_if.slave bus
);
  req_t req0, req1, req_clr;
  logic unused_clr_dir;

  logic               pend_clr, pend0, pend1, dir0, dir1;
  logic               pend_clr_n, pend0_n, pend1_n, dir0_n, dir1_n;
  logic [VALUE_W-1:0] value, value_n;
  logic               upd, upd_n, wrap, wrap_n;
  logic [VALUE_W:0]   res;

  enc_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .ACTIVE_LVL(1'b0)) u_ch0 (
    .clk(clk), .rst_n(rst_n), .tick(bus.tick),
    .a_async(bus.enc_a[0]), .b_async(bus.enc_b[0]), .req(req0));

  enc_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .ACTIVE_LVL(1'b0)) u_ch1 (
    .clk(clk), .rst_n(rst_n), .tick(bus.tick),
    .a_async(bus.enc_a[1]), .b_async(bus.enc_b[1]), .req(req1));

  enc_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .ACTIVE_LVL(1'b1)) u_clr (
    .clk(clk), .rst_n(rst_n), .tick(bus.tick),
    .a_async(bus.clr_sw), .b_async(1'b0), .req(req_clr));

  assign unused_clr_dir = req_clr.up;

  always_comb begin
    value_n    = value;
    upd_n      = 1'b0;
    wrap_n     = 1'b0;
    pend_clr_n = pend_clr;
    pend0_n    = pend0;
    pend1_n    = pend1;
    dir0_n     = dir0;
    dir1_n     = dir1;
    res        = '0;
    if (pend_clr) begin
      value_n    = '0;
      upd_n      = 1'b1;
      pend_clr_n = 1'b0;
      pend0_n    = 1'b0;
      pend1_n    = 1'b0;
    end else if (pend0) begin
      res     = step_value(value, STEP0, dir0);
      value_n = res[VALUE_W-1:0];
      upd_n   = 1'b1;
      wrap_n  = res[VALUE_W];
      pend0_n = 1'b0;
    end else if (pend1) begin
      res     = step_value(value, STEP1, dir1);
      value_n = res[VALUE_W-1:0];
      upd_n   = 1'b1;
      wrap_n  = res[VALUE_W];
      pend1_n = 1'b0;
    end
    // Freshly raised requests win over the drain of the same cycle.
    if (req_clr.valid) pend_clr_n = 1'b1;
    if (req0.valid) begin
      pend0_n = 1'b1;
      dir0_n  = req0.up;
    end
    if (req1.valid) begin
      pend1_n = 1'b1;
      dir1_n  = req1.up;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value    <= '0;
      upd      <= 1'b0;
      wrap     <= 1'b0;
      pend_clr <= 1'b0;
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      dir0     <= 1'b0;
      dir1     <= 1'b0;
    end else begin
      value    <= value_n;
      upd      <= upd_n;
      wrap     <= wrap_n;
      pend_clr <= pend_clr_n;
      pend0    <= pend0_n;
      pend1    <= pend1_n;
      dir0     <= dir0_n;
      dir1     <= dir1_n;
    end
  end

  assign bus.value = value;
  assign bus.upd   = upd;
  assign bus.wrap  = wrap;
endmodule

// File: doc/encoder_value_ctrl.md
# encoder_value_ctrl

Controller for the shared hex-display value register. It samples two rotary encoders and a clear switch on the slow sample strobe, debounces each input, and decodes encoder detents into up/down requests. It arbitrates all requests into one 24-bit value that drives the six-digit seven-segment display. It sits between the sample-tick timer and the display formatter.

## Interface
- DEBOUNCE_TICKS, 10: consecutive sample ticks an input must hold its active level before it is accepted.
- STEP0, 24'h000001: increment/decrement applied by encoder 0 (fine).
- STEP1, 24'h000100: increment/decrement applied by encoder 1 (coarse).
- clk  in  1  system clock. One clock domain only.
- rst_n  in  1  reset. Synchronous, active-low.
- tick  in  1  single-clk-cycle sample strobe from the timer.
- enc_a  in  2  encoder A phases; [0] = encoder 0. Asynchronous, idle high.
- enc_b  in  2  encoder B phases. Asynchronous.
- clr_sw  in  1  clear switch, active high. Asynchronous.
- value  out  24  current value. Resets to 0.
- upd  out  1  one-cycle pulse when value is written. Resets to 0.
- wrap  out  1  one-cycle pulse with upd when an add/subtract wraps. Resets to 0.

## Operation
- Each asynchronous input passes through a 2-flop synchronizer.
  - enc_a synchronizer flops reset to 1.
  - enc_b and clr_sw synchronizer flops reset to 0.
- Channel FSM, one per encoder. Advances only on cycles with tick=1.
  - IDLE: sync A=1. Tick counter held at 0. A=0 -> COUNT with counter=1.
  - COUNT: A=0 -> counter+1. When counter reaches DEBOUNCE_TICKS, sample sync B on that same tick and raise a request: B=0 means down, B=1 means up. Then go to FIRED. A=1 -> IDLE, no request.
  - FIRED: stay while A=0, so exactly one request is raised per detent. A=1 -> IDLE.
- Clear FSM uses the same three states on sync clr_sw with active level 1. It raises one clear request per press and re-arms after release.
- Requests set pending bits pend_clr, pend0 (with direction), pend1 (with direction). A raised request is registered as pending at the end of its tick cycle.
- Arbiter, one action per clk cycle, priority clr > ch0 > ch1:
  - clr: value <= 0 and pend0/pend1 are cleared (discarded). upd=1, wrap=0.
  - ch0: value <= value ± STEP0, computed modulo 2^24. pend0 cleared.
  - ch1: value <= value ± STEP1, computed modulo 2^24. pend1 cleared.
  - wrap=1 when an up-add carries out of bit 23 or a down-subtract borrows.
- A new request for a channel whose pending bit is still set overwrites the direction; the pending bit stays set. This is unreachable with DEBOUNCE_TICKS ≥ 1 because the arbiter drains within 3 clk cycles.

## Timing
- Request raised on tick cycle T: pending set at end of T, value/upd updated at end of T+1. Latency is 1 clk cycle after the tick.
- From the input edge, latency is 2 sync cycles plus DEBOUNCE_TICKS ticks plus 1 clk cycle.
- ch0 and ch1 requests on the same tick: ch0 applied at T+1, ch1 at T+2.
- clr together with any rotary request on the same tick: clear only; rotary requests dropped.
- tick asserted on consecutive clk cycles is legal. Each asserted cycle counts as one tick.
- rst_n=0 on any edge, including mid-COUNT or with requests pending:
  - All FSMs return to IDLE; counters and pending bits go to 0.
  - value=0, upd=0, wrap=0 on the following cycle.
  - No partial update is committed.

## Structure
- Package encoder_pkg holds:
  - enum enc_state_t {IDLE, COUNT, FIRED}
  - localparam VALUE_W = 24
  - typedef req_t {valid, up}
- Sub-module enc_debounce contains one synchronizer, one FSM and one tick counter, with active-level and sample-B outputs. It is instantiated three times: ch0, ch1, clear. The clear instance ignores B.
- Arbiter and value register stay in encoder_value_ctrl.

## Test plan
- Encoder 0 detent: hold enc_a[0]=0 with enc_b[0]=1 for 12 ticks. Require exactly one upd, value 0 -> 1, no repeat while A stays low.
- Bounce: toggle enc_a[0] low for 9 ticks then high. Require no upd. Repeat with enc_b[0]=0 for 10 ticks at value 0. Require value=24'hFFFFFF with wrap=1.
- Simultaneous: both encoders up on the same tick from 24'h0000FF. Require value 24'h000100 at T+1 and 24'h000200 at T+2, with upd high on both cycles.
- Clear priority: value 24'h123456; clr and encoder 1 up reach threshold on the same tick. Require value=0, a single upd, and no later STEP1 add.
- Reset mid-operation: assert rst_n=0 for 1 cycle while encoder 1 is in COUNT at 8 ticks. After release, require value=0 and that a further 2 ticks low produce no request; a full DEBOUNCE_TICKS is needed.
